// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and parity helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// rtl/uart_tx_drain_if.sv - FIFO pop side and serial line of the UART transmitter.
interface uart_tx_drain_if;
  import uart_pkg::*;

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_pop_data;
  logic                 fifo_pop;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    input  fifo_empty, fifo_pop_data,
    output fifo_pop, tx, tx_busy, tx_done
  );

  modport slave (
    output fifo_empty, fifo_pop_data,
    input  fifo_pop, tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16x oversample tick generator, counter parked at 0 while en is low.
module uart_baud_tick #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  import uart_pkg::*;

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - FIFO-draining 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_drain #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_drain_if.master    bus
);
  import uart_pkg::*;

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);

  tx_state_e            state_q, state_d;
  logic [OS_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 pop;
  logic                 tick;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  assign bit_end = tick && (tick_cnt_q == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    if (tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        // Pop is combinational so the head byte is captured on the same edge it leaves the FIFO.
        if (!bus.fifo_empty && !rst) begin
          pop     = 1'b1;
          shift_d = bus.fifo_pop_data;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(bus.fifo_pop_data);
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BI_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge as the state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign bus.fifo_pop = pop;
  assign bus.tx       = tx_q;
  assign bus.tx_busy  = (state_q != ST_IDLE);
  assign bus.tx_done  = done_q;

endmodule
